// File: rtl/fas_pkg.sv
// fas_pkg: shared sizing constants and issue-FSM encoding for the frame sequencer.
// Contents: N_PT (points per frame), DW (sample width), IDXW (frame index width),
//           TIMEOUT (wait-state watchdog limit), state_t (issue FSM states).
package fas_pkg;

  localparam int N_PT    = 16;
  localparam int DW      = 16;
  localparam int IDXW    = $clog2(N_PT);
  localparam int TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_FFT = 2'd2,
    WAIT_ANA = 2'd3
  } state_t;

endpackage

// File: rtl/fas_frame_buf.sv
// fas_frame_buf: two-bank ping-pong frame store, one write port, one full-frame read port.
// Latency: a write lands at the clock edge; rdat_o shows the selected bank one edge later (registered).
// Backpressure: none; the controller guarantees the bank being read is never written.
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-high reset (read register only)
//   we_i            write wd_i into bank wbank_i at index widx_i
//   rbank_i         bank presented on rdat_o; sample k at [k*DW +: DW]
module fas_frame_buf
  import fas_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               we_i,
  input  logic               wbank_i,
  input  logic [IDXW-1:0]    widx_i,
  input  logic [DW-1:0]      wd_i,
  input  logic               rbank_i,
  output logic [N_PT*DW-1:0] rdat_o
);

  // Sample storage has no reset: contents are meaningless until a frame is written.
  logic [DW-1:0]      mem_q [2][N_PT];
  logic [N_PT*DW-1:0] rdat_d;
  logic [N_PT*DW-1:0] rdat_q;

  always_ff @(posedge CLK) begin
    if (we_i) begin
      mem_q[wbank_i][widx_i] <= wd_i;
    end
  end

  always_comb begin
    rdat_d = '0;
    for (int k = 0; k < N_PT; k++) begin
      rdat_d[k*DW +: DW] = mem_q[rbank_i][k];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdat_q <= '0;
    end else begin
      rdat_q <= rdat_d;
    end
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/fas_frame_ctrl.sv
// fas_frame_ctrl: packs FIR samples into N_PT-point frames (ping-pong) and sequences FFT/analysis per frame.
// Latency: 16th sample written at edge E -> fft_start high in the cycle after E+1; next start 2 cycles after a release.
// Backpressure: none toward the FIR; a sample arriving while its bank is still full is dropped and overrun is set.
// Build option: FAS_TIMEOUT_EN adds an 8-bit wait watchdog (limit TIMEOUT); otherwise timeout is tied 0.
// Ports:
//   CLK, RST              clock (rising edge), asynchronous active-high reset
//   fir_valid, fir_d      input sample stream
//   fft_start, fft_din    frame launch pulse and flattened frame (sample k at [k*DW +: DW], k=0 oldest)
//   fft_valid, ana_done   completion pulses from FFT and analysis
//   busy, frame_cnt       FSM not idle; frames completed (wraps)
//   overrun, proto_err, timeout   sticky error flags
module fas_frame_ctrl
  import fas_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               fir_valid,
  input  logic [DW-1:0]      fir_d,
  output logic               fft_start,
  output logic [N_PT*DW-1:0] fft_din,
  input  logic               fft_valid,
  input  logic               ana_done,
  output logic               busy,
  output logic [7:0]         frame_cnt,
  output logic               overrun,
  output logic               proto_err,
  output logic               timeout
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_PT - 1);

  state_t          state_q, state_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [IDXW-1:0] wr_idx_q, wr_idx_d;
  logic [1:0]      full_q, full_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            overrun_q, overrun_d;
  logic            proto_err_q, proto_err_d;

  logic            wr_en;
  logic            release_bank;
  logic            count_frame;
  logic            wait_expire;

  // ---------------------------------------------------------------- watchdog
`ifdef FAS_TIMEOUT_EN
  localparam logic [7:0] WAIT_LIM = 8'(TIMEOUT);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;
  logic       in_wait;

  assign in_wait = (state_q == WAIT_FFT) || (state_q == WAIT_ANA);

  // Expires in the cycle whose closing edge brings the count to WAIT_LIM.
  assign wait_expire = in_wait && (wait_cnt_q == WAIT_LIM - 8'd1);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (in_wait) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // A regular completion in the same cycle wins over the watchdog.
  assign timeout_d = timeout_q |
                     (wait_expire &&
                      !((state_q == WAIT_FFT) && fft_valid) &&
                      !((state_q == WAIT_ANA) && ana_done));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign wait_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  // ---------------------------------------------------------------- issue FSM
  always_comb begin
    state_d      = state_q;
    release_bank = 1'b0;
    count_frame  = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT_FFT;
      end
      WAIT_FFT: begin
        if (fft_valid) begin
          state_d = WAIT_ANA;
        end else if (wait_expire) begin
          state_d      = IDLE;
          release_bank = 1'b1;
        end
      end
      WAIT_ANA: begin
        if (ana_done) begin
          state_d      = IDLE;
          release_bank = 1'b1;
          count_frame  = 1'b1;
        end else if (wait_expire) begin
          state_d      = IDLE;
          release_bank = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Each pulse is judged against the current state on its own.
  assign proto_err_d = proto_err_q |
                       (fft_valid && (state_q != WAIT_FFT)) |
                       (ana_done  && (state_q != WAIT_ANA));

  assign rd_bank_d   = release_bank ? ~rd_bank_q : rd_bank_q;
  assign frame_cnt_d = count_frame ? frame_cnt_q + 8'd1 : frame_cnt_q;

  // ---------------------------------------------------------------- fill side
  // Full is tested on the registered flag, so a bank released this cycle
  // still rejects a write in the same cycle.
  assign wr_en = fir_valid && !full_q[wr_bank_q];

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    overrun_d = overrun_q;
    full_d    = full_q;
    if (fir_valid) begin
      if (!full_q[wr_bank_q]) begin
        if (wr_idx_q == LAST_IDX) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
          wr_idx_d          = '0;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end
    // Set and clear never target the same bank: set needs it empty, clear needs it full.
    if (release_bank) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      full_q      <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      full_q      <= full_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
      proto_err_q <= proto_err_d;
    end
  end

  fas_frame_buf u_buf (
    .CLK     (CLK),
    .RST     (RST),
    .we_i    (wr_en),
    .wbank_i (wr_bank_q),
    .widx_i  (wr_idx_q),
    .wd_i    (fir_d),
    .rbank_i (rd_bank_q),
    .rdat_o  (fft_din)
  );

  assign fft_start = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign frame_cnt = frame_cnt_q;
  assign overrun   = overrun_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_fas_frame_ctrl.sv
// tb_fas_frame_ctrl: directed scenarios plus randomized traffic for fas_frame_ctrl.
// Reference: frames as a queue with completion cycles; a frame launches 2 cycles after
// the later of its completion and the previous release.
module tb_fas_frame_ctrl;

  logic         CLK = 1'b0;
  logic         RST;
  logic         fir_valid;
  logic [15:0]  fir_d;
  logic         fft_start;
  logic [255:0] fft_din;
  logic         fft_valid;
  logic         ana_done;
  logic         busy;
  logic [7:0]   frame_cnt;
  logic         overrun;
  logic         proto_err;
  logic         timeout;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  fas_frame_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .fir_valid (fir_valid),
    .fir_d     (fir_d),
    .fft_start (fft_start),
    .fft_din   (fft_din),
    .fft_valid (fft_valid),
    .ana_done  (ana_done),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .overrun   (overrun),
    .proto_err (proto_err),
    .timeout   (timeout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  logic [255:0] fq[$];       // completed frames awaiting release, oldest first
  int           fd[$];       // cycle in which each frame's last sample arrived
  logic [15:0]  part[$];     // samples of the frame being collected
  int           cyc      = 0;
  int           last_rel = -1000;
  bit           fft_seen = 1'b0;
  logic [7:0]   m_cnt    = 8'd0;
  bit           m_ovr    = 1'b0;
  bit           m_perr   = 1'b0;

  function automatic int head_start();
    int t;
    t = fd[0];
    if (last_rel > t) t = last_rel;
    return t + 2;
  endfunction

  always @(posedge CLK or posedge RST) begin : model
    int pend;
    bit fok;
    bit aok;
    logic [255:0] f;
    if (RST) begin
      fq.delete();
      fd.delete();
      part.delete();
      last_rel = -1000;
      fft_seen = 1'b0;
      m_cnt    = 8'd0;
      m_ovr    = 1'b0;
      m_perr   = 1'b0;
    end else begin
      pend = fq.size();
      fok  = (pend > 0) && (cyc > head_start()) && !fft_seen;
      aok  = (pend > 0) && fft_seen;
      if (fft_valid) begin
        if (fok) fft_seen = 1'b1;
        else     m_perr   = 1'b1;
      end
      if (ana_done) begin
        if (aok) begin
          void'(fq.pop_front());
          void'(fd.pop_front());
          m_cnt    = m_cnt + 8'd1;
          last_rel = cyc;
          fft_seen = 1'b0;
        end else begin
          m_perr = 1'b1;
        end
      end
      // Two banks: the bank being filled is free only while fewer than two frames are held.
      if (fir_valid) begin
        if (pend < 2) begin
          part.push_back(fir_d);
          if (part.size() == 16) begin
            f = '0;
            for (int k = 0; k < 16; k++) f[k*16 +: 16] = part[k];
            fq.push_back(f);
            fd.push_back(cyc);
            part.delete();
          end
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    cyc++;
  end

  always @(negedge CLK) begin : compare
    bit h;
    bit eb;
    bit es;
    int hs;
    if (chk_on) begin
      h  = fq.size() > 0;
      hs = h ? head_start() : 0;
      eb = h && (cyc >= hs);
      es = h && (cyc == hs);
      chk("busy",      256'(busy),      256'(eb));
      chk("fft_start", 256'(fft_start), 256'(es));
      chk("frame_cnt", 256'(frame_cnt), 256'(m_cnt));
      chk("overrun",   256'(overrun),   256'(m_ovr));
      chk("proto_err", 256'(proto_err), 256'(m_perr));
      chk("timeout",   256'(timeout),   256'(0));
      if (eb) chk("fft_din", fft_din, fq[0]);
    end
  end

  // ---------------------------------------------------------------- stimulus helpers
  task automatic drive(input bit fv, input logic [15:0] d, input bit f, input bit a);
    fir_valid = fv;
    fir_d     = d;
    fft_valid = f;
    ana_done  = a;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    fir_valid = 1'b0;
    fft_valid = 1'b0;
    ana_done  = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  function automatic logic [255:0] ramp(input logic [15:0] base);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[k*16 +: 16] = base + 16'(k);
    return v;
  endfunction

  // ---------------------------------------------------------------- scenarios
  initial begin
    RST = 1'b1; fir_valid = 1'b0; fir_d = '0; fft_valid = 1'b0; ana_done = 1'b0;
    @(posedge CLK); #1;
    chk_on = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;

    // reset state
    chk("rst busy",      256'(busy),      256'(0));
    chk("rst fft_start", 256'(fft_start), 256'(0));
    chk("rst frame_cnt", 256'(frame_cnt), 256'(0));
    chk("rst flags",     256'({overrun, proto_err, timeout}), 256'(0));
    chk("rst fft_din",   fft_din, 256'(0));

    // T1: one frame 0..15, start exactly two cycles after the 16th sample
    for (int k = 0; k < 16; k++) drive(1'b1, 16'(k), 1'b0, 1'b0);
    chk("t1 start early", 256'(fft_start), 256'(0));
    idle(1);
    chk("t1 start",  256'(fft_start), 256'(1));
    chk("t1 busy",   256'(busy),      256'(1));
    chk("t1 fft_din", fft_din, ramp(16'h0000));

    // T2: fft_valid 10 cycles later, ana_done 5 cycles after that
    idle(10);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    idle(4);
    chk("t2 busy before done", 256'(busy), 256'(1));
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    chk("t2 busy",      256'(busy),      256'(0));
    chk("t2 frame_cnt", 256'(frame_cnt), 256'(1));
    chk("t2 proto_err", 256'(proto_err), 256'(0));

    // T3/T4: 48 samples nonstop, third frame dropped, back-to-back launch of frame 1
    do_reset();
    for (int k = 0; k < 48; k++) drive(1'b1, 16'h0100 + 16'(k), 1'b0, 1'b0);
    chk("t3 overrun", 256'(overrun), 256'(1));
    chk("t3 fft_din", fft_din, ramp(16'h0100));
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    chk("t4 start gap", 256'(fft_start), 256'(0));
    chk("t4 frame_cnt", 256'(frame_cnt), 256'(1));
    idle(1);
    chk("t4 start",   256'(fft_start), 256'(1));
    chk("t4 fft_din", fft_din, ramp(16'h0110));

    // T5: fft_valid in WAIT_ANA, then ana_done in IDLE
    do_reset();
    for (int k = 0; k < 16; k++) drive(1'b1, 16'h0200 + 16'(k), 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 16'h0, 1'b0, 1'b0);            // ISSUE cycle
    drive(1'b0, 16'h0, 1'b1, 1'b0);            // accepted in WAIT_FFT
    chk("t5 no err yet", 256'(proto_err), 256'(0));
    drive(1'b0, 16'h0, 1'b1, 1'b0);            // stray fft_valid in WAIT_ANA
    chk("t5 err wait_ana", 256'(proto_err), 256'(1));
    chk("t5 busy held",    256'(busy),      256'(1));
    chk("t5 cnt held",     256'(frame_cnt), 256'(0));
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    chk("t5 cnt after",    256'(frame_cnt), 256'(1));
    drive(1'b0, 16'h0, 1'b0, 1'b1);            // stray ana_done in IDLE
    chk("t5 idle cnt",     256'(frame_cnt), 256'(1));
    chk("t5 idle busy",    256'(busy),      256'(0));

    // T7: reset after 7 samples discards the partial frame
    do_reset();
    for (int k = 0; k < 7; k++) drive(1'b1, 16'hAAA0 + 16'(k), 1'b0, 1'b0);
    RST = 1'b1;
    fir_valid = 1'b0;
    #1;
    chk("t7 rst outs", 256'({busy, fft_start, overrun, proto_err, timeout}), 256'(0));
    chk("t7 rst cnt",  256'(frame_cnt), 256'(0));
    chk("t7 rst din",  fft_din, 256'(0));
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int k = 0; k < 16; k++) drive(1'b1, 16'h0300 + 16'(k), 1'b0, 1'b0);
    idle(1);
    chk("t7 start",   256'(fft_start), 256'(1));
    chk("t7 fft_din", fft_din, ramp(16'h0300));

    // randomized traffic with occasional mid-run resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      drive($urandom_range(0, 9) < 7, 16'($urandom),
            $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
